// File: rtl/uart_send_arbiter.sv
// uart_send_arbiter: round-robin sharing of one UART transmit path among four byte requesters; UART_ARB_TIMEOUT_EN adds a WAIT-state timeout abort
module uart_send_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ack_o,
  output logic [N_REQ-1:0]   req_done_o,
  output logic               req_err_o,
  output logic [1:0]         grant_id_o,
  output logic               arb_busy_o,
  output logic               send_start_o,
  output logic [7:0]         send_data_o,
  input  logic               send_busy_i,
  input  logic               send_finish_i
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t             state_q;
  logic [1:0]         ptr_q, grant_id_q, win;
  logic [N_REQ-1:0]   req_ack_q, req_done_q;
  logic               req_err_q, arb_busy_q, send_start_q;
  logic [7:0]         send_data_q;
  logic               grant, fin, tmo;
  // first pending requester at or above the rotating pointer, wrapping mod 4
  always_comb begin
    win = ptr_q;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_i[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
  end
  assign grant = (state_q == IDLE) && (|req_i) && !send_busy_i;
  assign fin   = (state_q == WAIT) && send_finish_i && !send_start_q;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  // WAIT-cycle counter, restarted on every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (grant) cnt_q <= '0;
    else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;
  end
  assign tmo = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif
  // arbitration FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grant_id_q   <= '0;
      req_ack_q    <= '0;
      req_done_q   <= '0;
      req_err_q    <= 1'b0;
      arb_busy_q   <= 1'b0;
      send_start_q <= 1'b0;
      send_data_q  <= '0;
    end else begin
      req_ack_q    <= '0;
      req_done_q   <= '0;
      req_err_q    <= 1'b0;
      send_start_q <= 1'b0;
      if (grant) begin
        send_data_q  <= req_data_i[{win, 3'b000} +: 8];
        grant_id_q   <= win;
        req_ack_q    <= N_REQ'(1) << win;
        send_start_q <= 1'b1;
        ptr_q        <= win + 2'd1;
        arb_busy_q   <= 1'b1;
        state_q      <= WAIT;
      end else if (fin || tmo) begin
        req_done_q <= N_REQ'(1) << grant_id_q;
        req_err_q  <= !fin;
        arb_busy_q <= 1'b0;
        state_q    <= IDLE;
      end
    end
  end
  assign req_ack_o    = req_ack_q;
  assign req_done_o   = req_done_q;
  assign req_err_o    = req_err_q;
  assign grant_id_o   = grant_id_q;
  assign arb_busy_o   = arb_busy_q;
  assign send_start_o = send_start_q;
  assign send_data_o  = send_data_q;
endmodule

// File: tb/tb_uart_send_arbiter.sv
// tb_uart_send_arbiter: directed and randomized checks of the round-robin UART send arbiter
module tb_uart_send_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        send_busy = 1'b0, send_finish = 1'b0;
  logic [3:0]  req_ack, req_done;
  logic        req_err, arb_busy, send_start;
  logic [1:0]  grant_id;
  logic [7:0]  send_data;
  int          checks = 0, errors = 0;
  int          ptr = 0;
  always #5 clk = ~clk;
  uart_send_arbiter #(.N_REQ(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_data_i(req_data),
    .req_ack_o(req_ack), .req_done_o(req_done), .req_err_o(req_err),
    .grant_id_o(grant_id), .arb_busy_o(arb_busy), .send_start_o(send_start),
    .send_data_o(send_data), .send_busy_i(send_busy), .send_finish_i(send_finish)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_ack"}, 32'(req_ack), 0);
    check({tag, "_done"}, 32'(req_done), 0);
    check({tag, "_err"}, 32'(req_err), 0);
    check({tag, "_gid"}, 32'(grant_id), 0);
    check({tag, "_busy"}, 32'(arb_busy), 0);
    check({tag, "_start"}, 32'(send_start), 0);
    check({tag, "_data"}, 32'(send_data), 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0; req = '0; send_finish = 1'b0; send_busy = 1'b0;
    step(); step();
    rst_n = 1'b1;
    ptr = 0;
    step();
  endtask
  task automatic wait_start(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!send_start && n < 50);
    if (!send_start) check({tag, "_start_timeout"}, 0, 1);
  endtask
  task automatic finish_frame(input string tag, input int id);
    send_finish = 1'b1;
    step();
    send_finish = 1'b0;
    check({tag, "_done"}, 32'(req_done), 32'(1) << id);
    check({tag, "_err"}, 32'(req_err), 0);
    check({tag, "_busy_low"}, 32'(arb_busy), 0);
  endtask
  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++)
      if (m[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction
  initial begin
    int n;
    rst_n = 1'b0;
    step();
    check_zero("reset");
    do_reset();
    req = 4'b0100; req_data = 32'h005A_0000;
    step();
    check("single_ack", 32'(req_ack), 32'b0100);
    check("single_start", 32'(send_start), 1);
    check("single_data", 32'(send_data), 32'h5A);
    check("single_gid", 32'(grant_id), 2);
    check("single_busy", 32'(arb_busy), 1);
    req = '0; req_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 19; i++) begin
      step();
      if (send_start || req_done != 0 || send_data != 8'h5A || !arb_busy) check("single_wait", 0, 1);
    end
    finish_frame("single", 2);
    step();
    check("single_done_pulse", 32'(req_done), 0);
    do_reset();
    req = 4'b1111; req_data = 32'h4433_2211;
    for (int i = 0; i < 4; i++) begin
      wait_start("rr", n);
      if (i > 0) check("rr_gap", n + 1, 2);
      check("rr_gid", 32'(grant_id), i);
      check("rr_data", 32'(send_data), 32'h11 * (i + 1));
      check("rr_ack", 32'(req_ack), 32'(1) << i);
      req[i] = 1'b0;
      step(); step(); step();
      finish_frame("rr", i);
    end
    do_reset();
    req = 4'b0100; req_data = 32'h00C3_0000;
    wait_start("fair_a", n);
    check("fair_a_gid", 32'(grant_id), 2);
    req = 4'b0101; req_data = 32'h0055_00AA;
    step(); step();
    finish_frame("fair_a", 2);
    wait_start("fair_b", n);
    check("fair_b_gid", 32'(grant_id), 0);
    check("fair_b_data", 32'(send_data), 32'hAA);
    step();
    finish_frame("fair_b", 0);
    wait_start("fair_c", n);
    check("fair_c_gid", 32'(grant_id), 2);
    check("fair_c_data", 32'(send_data), 32'h55);
    req = '0;
    step();
    finish_frame("fair_c", 2);
    do_reset();
    send_busy = 1'b1; req = 4'b0001; req_data = 32'h0000_0077;
    for (int i = 0; i < 5; i++) begin
      step();
      check("busy_nostart", 32'(send_start), 0);
    end
    send_busy = 1'b0; send_finish = 1'b1;
    step();
    check("busy_release_start", 32'(send_start), 1);
    check("idle_finish_ignored", 32'(req_done), 0);
    req = '0;
    step();
    send_finish = 1'b0;
    check("first_cycle_finish_ignored", 32'(req_done), 0);
    check("first_cycle_busy", 32'(arb_busy), 1);
    step();
    finish_frame("busy", 0);
    do_reset();
    req = 4'b1000; req_data = 32'hBB00_0000;
    wait_start("rst_mid", n);
    req = 4'b1001; req_data = 32'hBB00_00CC;
    step(); step();
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid_async");
    send_finish = 1'b1;
    step(); step();
    check_zero("rst_mid_held");
    rst_n = 1'b1; send_finish = 1'b0;
    wait_start("rst_after", n);
    check("rst_after_gid", 32'(grant_id), 0);
    check("rst_after_data", 32'(send_data), 32'hCC);
`ifdef UART_ARB_TIMEOUT_EN
    do_reset();
    req = 4'b0010; req_data = 32'h0000_9900;
    wait_start("tmo", n);
    req = '0;
    n = 0;
    do begin
      step();
      n++;
    end while (req_done == 0 && n < 300);
    check("tmo_cycles", n, 100);
    check("tmo_done", 32'(req_done), 32'b0010);
    check("tmo_err", 32'(req_err), 1);
    check("tmo_idle", 32'(arb_busy), 0);
`endif
    do_reset();
    for (int t = 0; t < 200; t++) begin
      logic [3:0]  m;
      logic [31:0] d;
      logic        b;
      int          w, dly;
      m = 4'($urandom); d = $urandom; b = ($urandom_range(0, 3) == 0);
      req = m; req_data = d; send_busy = b;
      step();
      w = b ? -1 : pick(m, ptr);
      if (w < 0) begin
        check("rnd_nostart", 32'(send_start), 0);
        check("rnd_idle", 32'(arb_busy), 0);
      end else begin
        check("rnd_start", 32'(send_start), 1);
        check("rnd_gid", 32'(grant_id), w);
        check("rnd_ack", 32'(req_ack), 32'(1) << w);
        check("rnd_data", 32'(send_data), 32'(d[8*w +: 8]));
        ptr = (w + 1) % 4;
        dly = $urandom_range(1, 6);
        for (int j = 0; j < dly; j++) begin
          req = 4'($urandom); req_data = $urandom; send_busy = $urandom_range(0, 1) == 1;
          send_finish = (j == 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
          step();
          check("rnd_hold", 32'(send_data), 32'(d[8*w +: 8]));
          check("rnd_nodone", 32'(req_done), 0);
          check("rnd_busy", 32'(arb_busy), 1);
        end
        finish_frame("rnd", w);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_send_arbiter.md
# uart_send_arbiter

Round-robin arbiter that shares one UART transmit path among four byte requesters. It picks one pending requester and latches its byte. It issues a one-cycle `send_start` to the UART transmit side, holds `send_data` stable for the whole frame, then waits for `send_finish` and reports completion to the granted requester. It sits between the bus-side producers and the `send_*` port group of the `uart` top.

## Interface
- `N_REQ`, 4: number of requesters; fixed at 4 (grant index is 2 bits).
- `TIMEOUT`, 65535: cycles allowed in WAIT before abort; only used with `UART_ARB_TIMEOUT_EN`. Must exceed 10×BAUD.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous reset, active low.
- `req`  in  4  per-requester request level; held until `req_ack`.
- `req_data`  in  32  packed bytes; requester i owns bits [8i+7:8i].
- `req_ack`  out  4  one-hot one-cycle pulse when requester's byte is latched.
- `req_done`  out  4  one-hot one-cycle pulse when that requester's frame ends.
- `req_err`  out  1  one-cycle pulse coincident with `req_done` on timeout abort.
- `grant_id`  out  2  index of the current or last granted requester.
- `arb_busy`  out  1  high while a frame is owned (state WAIT).
- `send_start`  out  1  one-cycle start pulse to the UART transmitter.
- `send_data`  out  8  byte to transmit; stable from `send_start` until `req_done`.
- `send_busy`  in  1  UART transmitter busy.
- `send_finish`  in  1  UART transmitter end-of-frame pulse.

## Operation
- States: IDLE, WAIT. Reset state IDLE.
- IDLE: grant when `req != 0` and `send_busy == 0`.
  - Winner is the first set bit searching upward (mod 4) from `ptr`.
  - On the grant edge:
    - `send_data <= req_data[winner]`
    - `grant_id <= winner`
    - `req_ack[winner] <= 1`
    - `send_start <= 1`
    - `ptr <= winner+1 mod 4`
    - state to WAIT.
- WAIT: `arb_busy = 1`; no new grant; `req` changes ignored.
  - When `send_finish == 1`: `req_done[grant_id] <= 1`, state to IDLE.
- `send_finish` while in IDLE is ignored.
- `send_finish` in the first WAIT cycle (the cycle `send_start` is high) is ignored.
- `ptr` resets to 0, so requester 0 has top priority after reset.
- A requester dropping `req` before `req_ack` is simply not considered; no error is raised.
- `req_data` is sampled only on the grant edge; later changes do not affect `send_data`.
- Reset mid-frame:
  - All outputs go to 0 immediately; state IDLE, `ptr = 0`.
  - The in-flight requester gets no `req_done`.
  - The UART is reset by the same `rst_n`.

## Timing
- Reset values: `req_ack = 0`, `req_done = 0`, `req_err = 0`, `grant_id = 0`, `arb_busy = 0`, `send_start = 0`, `send_data = 8'h00`.
- All outputs are registered.
- `req` sampled high in IDLE at cycle 0 → `req_ack` and `send_start` high in cycle 1, `arb_busy` high from cycle 1.
- `send_finish` high in WAIT cycle F → `req_done` high in cycle F+1, `arb_busy` low in cycle F+1.
- Back-to-back: if another `req` is pending and `send_busy == 0` in F+1, the next `send_start` fires in cycle F+2.
- Simultaneous requests are resolved in one cycle by the rotating priority; there is no extra latency for contention.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter of width clog2(TIMEOUT+1) clears on grant and increments each WAIT cycle.
  - If it reaches `TIMEOUT` without `send_finish`: `req_done[grant_id]` and `req_err` pulse together, state to IDLE.
  - If `send_finish` and timeout occur in the same cycle, `send_finish` wins and `req_err` stays 0.
- Not defined:
  - No counter; WAIT persists until `send_finish` or reset.
  - `req_err` is tied to 0.

## Test plan
- Single request: `req = 4'b0100`, byte 0x5A.
  - `req_ack = 4'b0100` and `send_start` one cycle later; `send_data = 0x5A`.
  - Model asserts `send_finish` 20 cycles after start → `req_done = 4'b0100` next cycle.
- All four request at once after reset, bytes 0x11/0x22/0x33/0x44 held.
  - Grants in order 0,1,2,3; `send_data` sequence 0x11,0x22,0x33,0x44.
  - Each `send_start` is 2 cycles after the previous `send_finish`.
- Fairness: after requester 2 is granted, `req = 4'b0101` → requester 0 is granted next (search from 3 wraps to 0).
  - Then `req = 4'b0101` again → requester 2 is granted.
- Busy blocking: `send_busy` forced 1 with `req = 4'b0001` → no `send_start` while busy.
  - `send_busy` drops at cycle T → `send_start` in cycle T+1.
- With `UART_ARB_TIMEOUT_EN` and `TIMEOUT = 100`: grant with no `send_finish`.
  - `req_done` and `req_err` pulse exactly 100 WAIT cycles after grant; state returns to IDLE.
- Reset mid-frame: assert `rst_n = 0` in WAIT.
  - All outputs read 0 in the same cycle; no `req_done` follows.
  - After release, requester 0 wins over pending requester 3.
